// File: rtl/score_keeper.sv
// Multi-player BCD score keeper with a PLAY/WON game FSM.
// Per-player decimal counters; the first player(s) to reach WIN_SCORE end the game.
module score_keeper #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_DIGITS  = 2,
    parameter int WIN_SCORE   = 11,
    parameter int SATURATE    = 0,
    localparam int WW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PLAYERS-1:0]             inc,
    input  logic                               clr,
    output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] score_bcd,
    output logic                               game_over,
    output logic [WW-1:0]                      winner,
    output logic                               win_pulse
);

    localparam int SW        = NUM_DIGITS * 4;
    localparam int MAX_SCORE = (10 ** NUM_DIGITS) - 1;
    // A target beyond the representable range can never be reached.
    localparam bit WIN_EN    = (WIN_SCORE != 0) && (WIN_SCORE <= MAX_SCORE);

    function automatic logic [SW-1:0] to_bcd(input int value);
        logic [SW-1:0] bcd;
        int            rest;
        bcd  = '0;
        rest = value;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            bcd[d*4 +: 4] = 4'(rest % 10);
            rest          = rest / 10;
        end
        return bcd;
    endfunction

    localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    typedef enum logic {
        PLAY = 1'b0,
        WON  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WW-1:0]        r_winner;
    logic [WW-1:0]        w_winner_next;
    logic                 r_win_pulse;
    logic                 w_win_pulse_next;
    logic [NUM_PLAYERS-1:0] w_hit;
    logic [WW-1:0]        w_win_idx;
    logic                 w_any_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [SW-1:0] r_score;
            logic [SW-1:0] w_incr;
            logic [SW-1:0] w_next;
            logic          w_all9;

            // Ripple the decimal carry upward; w_all9 stays set while every digit so far was 9.
            always_comb begin
                w_incr = r_score;
                w_all9 = 1'b1;
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if (w_all9) begin
                        if (r_score[d*4 +: 4] >= 4'd9) begin
                            w_incr[d*4 +: 4] = 4'd0;
                        end else begin
                            w_incr[d*4 +: 4] = r_score[d*4 +: 4] + 4'd1;
                            w_all9           = 1'b0;
                        end
                    end
                end
                if (w_all9 && (SATURATE != 0)) begin
                    w_incr = r_score;
                end
            end

            assign w_next     = ((r_state == PLAY) && inc[gi]) ? w_incr : r_score;
            assign w_hit[gi]  = WIN_EN && (r_state == PLAY) && inc[gi] && (w_incr == WIN_BCD);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_score <= '0;
                end else if (clr) begin
                    r_score <= '0;
                end else begin
                    r_score <= w_next;
                end
            end

            assign score_bcd[gi*SW +: SW] = r_score;
        end
    endgenerate

    // Scan from the top so the lowest-indexed hitting player wins ties.
    always_comb begin
        w_win_idx = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (w_hit[p]) begin
                w_win_idx = WW'(p);
            end
        end
        w_any_hit = |w_hit;
    end

    always_comb begin
        w_state_next     = r_state;
        w_winner_next    = r_winner;
        w_win_pulse_next = 1'b0;
        if (clr) begin
            w_state_next  = PLAY;
            w_winner_next = '0;
        end else begin
            case (r_state)
                PLAY: begin
                    w_winner_next = '0;
                    if (w_any_hit) begin
                        w_state_next     = WON;
                        w_winner_next    = w_win_idx;
                        w_win_pulse_next = 1'b1;
                    end
                end
                WON: begin
                    w_state_next = WON;
                end
                default: begin
                    w_state_next  = PLAY;
                    w_winner_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= PLAY;
            r_winner    <= '0;
            r_win_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_winner    <= w_winner_next;
            r_win_pulse <= w_win_pulse_next;
        end
    end

    assign game_over = (r_state == WON);
    assign winner    = r_winner;
    assign win_pulse = r_win_pulse;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: three parameterisations driven in parallel
// and compared against an integer-score reference model.
module tb_score_keeper;

    logic        clk;
    logic        reset;
    logic [1:0]  inc;
    logic        clr;
    logic [15:0] sb [3];
    logic        go [3];
    logic [0:0]  win_o [3];
    logic        wp [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integer scores per instance/player
    int cfg_win [3] = '{11, 0, 0};
    int cfg_sat [3] = '{0, 0, 1};
    int m_score [3][2];
    int m_won   [3];
    int m_winner[3];
    int m_pulse [3];

    score_keeper #(.NUM_PLAYERS(2), .NUM_DIGITS(2), .WIN_SCORE(11), .SATURATE(0)) u_def (
        .clk(clk), .reset(reset), .inc(inc), .clr(clr),
        .score_bcd(sb[0]), .game_over(go[0]), .winner(win_o[0]), .win_pulse(wp[0]));

    score_keeper #(.NUM_PLAYERS(2), .NUM_DIGITS(2), .WIN_SCORE(0), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .inc(inc), .clr(clr),
        .score_bcd(sb[1]), .game_over(go[1]), .winner(win_o[1]), .win_pulse(wp[1]));

    score_keeper #(.NUM_PLAYERS(2), .NUM_DIGITS(2), .WIN_SCORE(0), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .inc(inc), .clr(clr),
        .score_bcd(sb[2]), .game_over(go[2]), .winner(win_o[2]), .win_pulse(wp[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dec(input logic [15:0] v, input int p);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[p*8 +: 4];
        hi = v[p*8+4 +: 4];
        if (lo > 4'd9 || hi > 4'd9) return -1;
        return int'(lo) + 10 * int'(hi);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_score[k][0] = 0;
            m_score[k][1] = 0;
            m_won[k]      = 0;
            m_winner[k]   = 0;
            m_pulse[k]    = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] iv, input logic cv);
        for (int k = 0; k < 3; k++) begin
            m_pulse[k] = 0;
            if (cv) begin
                m_score[k][0] = 0;
                m_score[k][1] = 0;
                m_won[k]      = 0;
                m_winner[k]   = 0;
            end else if (m_won[k] == 0) begin
                for (int p = 0; p < 2; p++) begin
                    if (iv[p]) begin
                        if (m_score[k][p] == 99) m_score[k][p] = (cfg_sat[k] != 0) ? 99 : 0;
                        else                     m_score[k][p] = m_score[k][p] + 1;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (m_won[k] == 0 && cfg_win[k] != 0 && cfg_win[k] <= 99 && iv[p]
                        && m_score[k][p] == cfg_win[k]) begin
                        m_won[k]    = 1;
                        m_winner[k] = p;
                        m_pulse[k]  = 1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of stimulus; returns 1 time unit after the capturing edge.
    task automatic step(input logic [1:0] iv, input logic cv);
        inc = iv;
        clr = cv;
        @(posedge clk);
        model_step(iv, cv);
        #1;
        inc = 2'b00;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inc   = 2'b00;
        clr   = 1'b0;
        model_reset();
        #3;
        n_tests++;
        if (sb[0] !== 16'h0000) begin n_fail++; $display("FAIL reset_score: got %h expected 0000", sb[0]); end
        n_tests++;
        if (go[0] !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b expected 0", go[0]); end
        n_tests++;
        if (win_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_winner: got %b expected 0", win_o[0]); end
        n_tests++;
        if (wp[0] !== 1'b0) begin n_fail++; $display("FAIL reset_win_pulse: got %b expected 0", wp[0]); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        n_tests++;
        if (sb[1] !== 16'h0000 || sb[2] !== 16'h0000) begin
            n_fail++; $display("FAIL reset_other: got %h/%h expected 0000/0000", sb[1], sb[2]);
        end
    endtask

    task automatic test_count_carry();
        for (int i = 0; i < 9; i++) step(2'b01, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h0009) begin n_fail++; $display("FAIL count_nine: got %h expected 0009", sb[0]); end
        step(2'b01, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h0010) begin n_fail++; $display("FAIL count_carry: got %h expected 0010", sb[0]); end
    endtask

    task automatic test_win_single();
        step(2'b00, 1'b1);
        for (int i = 0; i < 10; i++) step(2'b10, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h1000 || go[0] !== 1'b0) begin
            n_fail++; $display("FAIL win_pre: got %h go=%b expected 1000 go=0", sb[0], go[0]);
        end
        step(2'b10, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h1100) begin n_fail++; $display("FAIL win_score: got %h expected 1100", sb[0]); end
        n_tests++;
        if (go[0] !== 1'b1 || win_o[0] !== 1'b1 || wp[0] !== 1'b1) begin
            n_fail++; $display("FAIL win_flags: got go=%b winner=%b pulse=%b expected 1/1/1", go[0], win_o[0], wp[0]);
        end
        step(2'b11, 1'b0);
        n_tests++;
        if (wp[0] !== 1'b0) begin n_fail++; $display("FAIL win_pulse_len: got %b expected 0", wp[0]); end
        step(2'b11, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h1100 || go[0] !== 1'b1 || win_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL win_frozen: got %h go=%b winner=%b expected 1100 1 1", sb[0], go[0], win_o[0]);
        end
    endtask

    task automatic test_clr_in_won();
        step(2'b11, 1'b1);
        n_tests++;
        if (sb[0] !== 16'h0000 || go[0] !== 1'b0 || win_o[0] !== 1'b0 || wp[0] !== 1'b0) begin
            n_fail++; $display("FAIL clr_won: got %h go=%b winner=%b pulse=%b expected 0000 0 0 0",
                               sb[0], go[0], win_o[0], wp[0]);
        end
        step(2'b01, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h0001) begin n_fail++; $display("FAIL clr_resume: got %h expected 0001", sb[0]); end
    endtask

    task automatic test_tie();
        step(2'b00, 1'b1);
        for (int i = 0; i < 10; i++) step(2'b11, 1'b0);
        step(2'b11, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h1111) begin n_fail++; $display("FAIL tie_score: got %h expected 1111", sb[0]); end
        n_tests++;
        if (go[0] !== 1'b1 || win_o[0] !== 1'b0 || wp[0] !== 1'b1) begin
            n_fail++; $display("FAIL tie_winner: got go=%b winner=%b pulse=%b expected 1/0/1", go[0], win_o[0], wp[0]);
        end
    endtask

    task automatic test_wrap();
        step(2'b00, 1'b1);
        for (int i = 0; i < 99; i++) step(2'b01, 1'b0);
        n_tests++;
        if (sb[1] !== 16'h0099 || sb[2] !== 16'h0099) begin
            n_fail++; $display("FAIL wrap_99: got %h/%h expected 0099/0099", sb[1], sb[2]);
        end
        step(2'b01, 1'b0);
        n_tests++;
        if (sb[1] !== 16'h0000) begin n_fail++; $display("FAIL wrap_to_zero: got %h expected 0000", sb[1]); end
        n_tests++;
        if (sb[2] !== 16'h0099) begin n_fail++; $display("FAIL sat_hold: got %h expected 0099", sb[2]); end
        n_tests++;
        if (go[1] !== 1'b0 || go[2] !== 1'b0) begin
            n_fail++; $display("FAIL nowin_game_over: got %b/%b expected 0/0", go[1], go[2]);
        end
    endtask

    task automatic test_async_reset();
        step(2'b00, 1'b1);
        for (int i = 0; i < 5; i++) step(2'b11, 1'b0);
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h0507) begin n_fail++; $display("FAIL areset_pre: got %h expected 0507", sb[0]); end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (sb[0] !== 16'h0000 || sb[1] !== 16'h0000 || go[0] !== 1'b0) begin
            n_fail++; $display("FAIL areset_async: got %h/%h go=%b expected 0000/0000 0", sb[0], sb[1], go[0]);
        end
        #1;
        reset = 1'b1;
        model_reset();
        step(2'b01, 1'b0);
        n_tests++;
        if (sb[0] !== 16'h0001) begin n_fail++; $display("FAIL areset_resume: got %h expected 0001", sb[0]); end
    endtask

    task automatic test_random();
        logic [1:0] iv;
        logic       cv;
        int         got;
        step(2'b00, 1'b1);
        for (int i = 0; i < 400; i++) begin
            iv = 2'($urandom_range(0, 3));
            cv = ($urandom_range(0, 29) == 0);
            step(iv, cv);
            for (int k = 0; k < 3; k++) begin
                for (int p = 0; p < 2; p++) begin
                    got = dec(sb[k], p);
                    n_tests++;
                    if (got !== m_score[k][p]) begin
                        n_fail++;
                        $display("FAIL rand_score cyc=%0d inst=%0d p=%0d: got %0d expected %0d", i, k, p, got, m_score[k][p]);
                    end
                end
                n_tests++;
                if (go[k] !== (m_won[k] != 0) || wp[k] !== (m_pulse[k] != 0)
                    || int'(win_o[k]) !== m_winner[k]) begin
                    n_fail++;
                    $display("FAIL rand_flags cyc=%0d inst=%0d: got go=%b pulse=%b winner=%0d expected %0d %0d %0d",
                             i, k, go[k], wp[k], win_o[k], m_won[k], m_pulse[k], m_winner[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_carry();
        test_win_single();
        test_clr_in_won();
        test_tie();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
